// File: rtl/cfi_log_queue.sv
// cfi_log_queue_pkg / cfi_log_queue
//
// Purpose: commit-stage control-flow logger. Each cycle up to NR_COMMIT_PORTS
// committing instructions are classified (branch / jal / jalr / call / return).
// They are filtered by the per-privilege flag mask and by NR_ADDR_REGIONS
// runtime PC windows. Accepted records enter a DEPTH-entry in-order FIFO that
// the CFI checker drains.
//
// Handshake: the head record is transferred when log_valid_o and log_ready_i
// are both high at a rising clock edge. log_valid_o depends only on registered
// state. log_o and log_priv_o hold steady while log_valid_o is high and
// log_ready_i is low. Acceptance of new records never depends on log_ready_i.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   flush_i                synchronous queue clear (drop counter kept)
//   instr_i, commit_ack_i  commit-port entries and per-port commit strobes
//   flags_{m,h,s,u}_i      per-privilege record-type masks
//   priv_lvl_i             current privilege level
//   region_en_i/base_i/limit_i  PC windows [base, limit), unsigned compares
//   log_o, log_priv_o, log_valid_o, log_ready_i  FIFO head and handshake
//   stall_o                free entries < NR_COMMIT_PORTS
//   drop_cnt_o             saturating count of records dropped for lack of space
//
// Configuration macro: CFI_LOG_DROP_CNT_EN builds the drop counter. When the
// macro is not defined, drop_cnt_o is tied to zero.

package cfi_log_queue_pkg;
    localparam int VLEN = 32;

    typedef enum logic [1:0] {
        PRIV_LVL_U  = 2'b00,
        PRIV_LVL_S  = 2'b01,
        PRIV_LVL_HS = 2'b10,
        PRIV_LVL_M  = 2'b11
    } priv_lvl_t;

    typedef enum logic [2:0] {FU_NONE, LOAD, STORE, ALU, CTRL_FLOW, MULT, CSR} fu_t;

    typedef enum logic [3:0] {ADD, SUB, EQ, NE, LTS, GES, LTU, GEU, JALR, OP_OTHER} fu_op_t;

    typedef struct packed {
        logic [VLEN-1:0] predict_address;
    } bp_resolve_t;

    typedef struct packed {
        logic [VLEN-1:0] pc;
        fu_t             fu;
        fu_op_t          op;
        logic [4:0]      rs1;
        logic [4:0]      rd;
        logic [VLEN-1:0] result;
        logic            valid;
        bp_resolve_t     bp;
    } scoreboard_entry_t;

    typedef struct packed {
        logic is_branch;
        logic is_jump;
        logic is_jal;
        logic is_jalr;
        logic is_call;
        logic is_return;
    } cfi_flags_t;

    typedef struct packed {
        logic [VLEN-1:0] pc;
        logic [VLEN-1:0] npc;
        logic [VLEN-1:0] target;
        cfi_flags_t      flags;
    } cfi_log_t;
endpackage

module cfi_log_queue
    import cfi_log_queue_pkg::*;
#(
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned DEPTH           = 8,   // power of two, >= 2
    parameter int unsigned NR_ADDR_REGIONS = 2
) (
    input  logic                                       clk_i,
    input  logic                                       rst_ni,
    input  logic                                       flush_i,
    input  scoreboard_entry_t [NR_COMMIT_PORTS-1:0]    instr_i,
    input  logic [NR_COMMIT_PORTS-1:0]                 commit_ack_i,
    input  cfi_flags_t                                 flags_m_i,
    input  cfi_flags_t                                 flags_h_i,
    input  cfi_flags_t                                 flags_s_i,
    input  cfi_flags_t                                 flags_u_i,
    input  priv_lvl_t                                  priv_lvl_i,
    input  logic [NR_ADDR_REGIONS-1:0]                 region_en_i,
    input  logic [NR_ADDR_REGIONS-1:0][VLEN-1:0]       region_base_i,
    input  logic [NR_ADDR_REGIONS-1:0][VLEN-1:0]       region_limit_i,
    output cfi_log_t                                   log_o,
    output priv_lvl_t                                  log_priv_o,
    output logic                                       log_valid_o,
    input  logic                                       log_ready_i,
    output logic                                       stall_o,
    output logic [15:0]                                drop_cnt_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    cfi_log_t  mem      [DEPTH];
    priv_lvl_t priv_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;

    cfi_log_t [NR_COMMIT_PORTS-1:0]              rec;
    logic     [NR_COMMIT_PORTS-1:0]              pc_ok;
    logic     [NR_COMMIT_PORTS-1:0]              match;
    logic     [NR_COMMIT_PORTS-1:0]              push_en;
    logic     [NR_COMMIT_PORTS-1:0][PTR_W-1:0]   slot;
    cfi_flags_t       mask;
    logic [CNT_W-1:0] free, n_match, n_push;
    logic             pop;

    always_comb begin
        case (priv_lvl_i)
            PRIV_LVL_M:  mask = flags_m_i;
            PRIV_LVL_HS: mask = flags_h_i;
            PRIV_LVL_S:  mask = flags_s_i;
            default:     mask = flags_u_i;
        endcase
    end

    // Classification and filtering. Non-control-flow entries get all-zero
    // flags, so the mask test rejects them.
    always_comb begin
        rec   = '0;
        pc_ok = '0;
        match = '0;
        for (int i = 0; i < int'(NR_COMMIT_PORTS); i++) begin
            if (instr_i[i].fu == CTRL_FLOW) begin
                rec[i].flags.is_branch = instr_i[i].op inside {EQ, NE, LTS, GES, LTU, GEU};
                rec[i].flags.is_jalr   = (instr_i[i].op == JALR);
                rec[i].flags.is_jal    = !rec[i].flags.is_branch && !rec[i].flags.is_jalr;
            end
            rec[i].flags.is_jump   = rec[i].flags.is_jal | rec[i].flags.is_jalr;
            rec[i].flags.is_call   = rec[i].flags.is_jump &&
                                     (instr_i[i].rd == 5'd1 || instr_i[i].rd == 5'd5);
            rec[i].flags.is_return = rec[i].flags.is_jalr &&
                                     (instr_i[i].rs1 == 5'd1 || instr_i[i].rs1 == 5'd5);
            rec[i].pc     = instr_i[i].pc;
            rec[i].npc    = instr_i[i].result;
            rec[i].target = instr_i[i].bp.predict_address;

            // No enabled window means no PC restriction. base >= limit can
            // never satisfy both compares, so such a window is empty.
            pc_ok[i] = (region_en_i == '0);
            for (int k = 0; k < int'(NR_ADDR_REGIONS); k++) begin
                if (region_en_i[k] && region_base_i[k] <= instr_i[i].pc &&
                    instr_i[i].pc < region_limit_i[k])
                    pc_ok[i] = 1'b1;
            end
            match[i] = instr_i[i].valid && commit_ack_i[i] &&
                       (|(mask & rec[i].flags)) && pc_ok[i];
        end
    end

    // Matches are packed into consecutive slots from wr_ptr, lowest port first.
    // Free space comes from the registered count only, so a pop in the same
    // cycle cannot make room (no ready-to-accept combinational path).
    always_comb begin
        free    = CNT_W'(DEPTH) - count;
        n_match = '0;
        n_push  = '0;
        push_en = '0;
        slot    = '0;
        for (int i = 0; i < int'(NR_COMMIT_PORTS); i++) begin
            slot[i] = wr_ptr + n_match[PTR_W-1:0];
            if (match[i]) begin
                if (n_match < free) begin
                    push_en[i] = 1'b1;
                    n_push     = n_push + 1'b1;
                end
                n_match = n_match + 1'b1;
            end
        end
    end

    assign log_valid_o = (count != '0);
    assign pop         = log_valid_o && log_ready_i;
    assign stall_o     = (free < CNT_W'(NR_COMMIT_PORTS));
    assign log_o       = mem[rd_ptr];
    assign log_priv_o  = priv_mem[rd_ptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int j = 0; j < int'(DEPTH); j++) begin
                mem[j]      <= '0;
                priv_mem[j] <= PRIV_LVL_M;
            end
        end else if (flush_i) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            for (int i = 0; i < int'(NR_COMMIT_PORTS); i++) begin
                if (push_en[i]) begin
                    mem[slot[i]]      <= rec[i];
                    priv_mem[slot[i]] <= priv_lvl_i;
                end
            end
            wr_ptr <= wr_ptr + n_push[PTR_W-1:0];
            rd_ptr <= rd_ptr + PTR_W'(pop);
            count  <= count + n_push - CNT_W'(pop);
        end
    end

`ifdef CFI_LOG_DROP_CNT_EN
    logic [15:0]      drop_cnt;
    logic [CNT_W-1:0] n_drop;
    logic [16:0]      drop_sum;

    assign n_drop   = n_match - n_push;
    assign drop_sum = {1'b0, drop_cnt} + 17'(n_drop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            drop_cnt <= '0;
        else if (!flush_i)
            drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    assign drop_cnt_o = drop_cnt;
`else
    assign drop_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cfi_log_queue.sv
module tb_cfi_log_queue;
    import cfi_log_queue_pkg::*;

    localparam int NR    = 2;
    localparam int DEPTH = 8;
    localparam int NREG  = 2;
    localparam int RW    = $bits(cfi_log_t) + 2;

    // ---------------- clock / reset ----------------
    logic clk    = 1'b0;
    logic rst_ni = 1'b1;
    always #5 clk = ~clk;

    logic                        flush;
    scoreboard_entry_t [NR-1:0]  instr;
    logic [NR-1:0]               ack;
    cfi_flags_t                  fl_m, fl_h, fl_s, fl_u;
    priv_lvl_t                   priv;
    logic [NREG-1:0]             ren;
    logic [NREG-1:0][31:0]       rbase, rlim;
    cfi_log_t                    log_rec;
    priv_lvl_t                   log_priv;
    logic                        log_valid, log_ready, stall;
    logic [15:0]                 drop_cnt;

    cfi_log_queue #(.NR_COMMIT_PORTS(NR), .DEPTH(DEPTH), .NR_ADDR_REGIONS(NREG)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush),
        .instr_i(instr), .commit_ack_i(ack),
        .flags_m_i(fl_m), .flags_h_i(fl_h), .flags_s_i(fl_s), .flags_u_i(fl_u),
        .priv_lvl_i(priv),
        .region_en_i(ren), .region_base_i(rbase), .region_limit_i(rlim),
        .log_o(log_rec), .log_priv_o(log_priv), .log_valid_o(log_valid),
        .log_ready_i(log_ready), .stall_o(stall), .drop_cnt_o(drop_cnt)
    );

    // ---------------- scoreboard state ----------------
    logic [RW-1:0] exp_q[$];      // {priv, record}, oldest first
    int new_cnt;                  // entries pushed to exp_q this cycle (not yet visible)
    int drop_model, drop_pend;
    int n_cmp, n_bad;
    bit mon_en;
    int mon_old;
    logic [RW-1:0] mon_e;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic cfi_flags_t classify(input scoreboard_entry_t e);
        cfi_flags_t f = '0;
        if (e.fu == CTRL_FLOW) begin
            case (e.op)
                EQ, NE, LTS, GES, LTU, GEU: f.is_branch = 1'b1;
                JALR:                       f.is_jalr   = 1'b1;
                default:                    f.is_jal    = 1'b1;
            endcase
            f.is_jump   = f.is_jal | f.is_jalr;
            f.is_call   = f.is_jump && (e.rd == 5'd1 || e.rd == 5'd5);
            f.is_return = f.is_jalr && (e.rs1 == 5'd1 || e.rs1 == 5'd5);
        end
        return f;
    endfunction

    function automatic cfi_flags_t mask_for(input priv_lvl_t p);
        case (p)
            PRIV_LVL_M:  return fl_m;
            PRIV_LVL_HS: return fl_h;
            PRIV_LVL_S:  return fl_s;
            default:     return fl_u;
        endcase
    endfunction

    function automatic bit pc_pass(input logic [31:0] pc);
        if (ren == '0) return 1'b1;
        for (int k = 0; k < NREG; k++)
            if (ren[k] && pc >= rbase[k] && pc < rlim[k]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [RW-1:0] expect_entry(input scoreboard_entry_t e);
        cfi_log_t r;
        r.pc     = e.pc;
        r.npc    = e.result;
        r.target = e.bp.predict_address;
        r.flags  = classify(e);
        return {priv, r};
    endfunction

    function automatic int exp_drop();
`ifdef CFI_LOG_DROP_CNT_EN
        return drop_model;
`else
        return 0;
`endif
    endfunction

    // ---------------- driver tasks ----------------
    // Called at posedge+1 with this cycle's inputs already applied; predicts
    // the cycle's effect, then advances to the next posedge+1.
    task automatic step();
        int free, acc;
        if (!flush) begin
            free = DEPTH - exp_q.size();
            acc  = 0;
            for (int i = 0; i < NR; i++) begin
                if (instr[i].valid && ack[i] && (|(mask_for(priv) & classify(instr[i]))) &&
                    pc_pass(instr[i].pc)) begin
                    if (acc < free) begin
                        exp_q.push_back(expect_entry(instr[i]));
                        acc++;
                        new_cnt++;
                    end else begin
                        drop_pend++;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        new_cnt = 0;
        if (flush) exp_q.delete();
        drop_model = (drop_model + drop_pend > 65535) ? 65535 : drop_model + drop_pend;
        drop_pend  = 0;
    endtask

    task automatic set_port(input int i, input fu_t f, input fu_op_t o, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [31:0] pc);
        instr[i].valid  = 1'b1;
        instr[i].fu     = f;
        instr[i].op     = o;
        instr[i].rd     = rd;
        instr[i].rs1    = rs1;
        instr[i].pc     = pc;
        instr[i].result = pc + 32'd4;
        instr[i].bp.predict_address = pc + 32'h40;
    endtask

    task automatic drain(input int n);
        ack       = '0;
        flush     = 1'b0;
        log_ready = 1'b1;
        repeat (n) step();
        log_ready = 1'b0;
    endtask

    task automatic do_reset();
        ack   = '0;
        flush = 1'b0;
        rst_ni = 1'b0;
        #1;
        check("rst_valid", log_valid, 1'b0);
        check("rst_stall", stall, 1'b0);
        check("rst_log", log_rec, '0);
        check("rst_priv", log_priv, PRIV_LVL_M);
        check("rst_drop", drop_cnt, 16'h0);
        exp_q.delete();
        new_cnt = 0; drop_model = 0; drop_pend = 0;
        @(posedge clk);
        #2 rst_ni = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic scoreboard_entry_t rand_instr();
        scoreboard_entry_t e;
        logic [4:0] regs [4] = '{5'd0, 5'd1, 5'd5, 5'd7};
        e.valid  = ($urandom_range(0, 7) != 0);
        e.fu     = ($urandom_range(0, 3) != 0) ? CTRL_FLOW : ALU;
        e.op     = fu_op_t'(4'($urandom_range(0, 9)));
        e.rd     = regs[$urandom_range(0, 3)];
        e.rs1    = regs[$urandom_range(0, 3)];
        case ($urandom_range(0, 5))
            0:       e.pc = 32'h8000_0000;
            1:       e.pc = 32'h8FFF_FFFC;
            2:       e.pc = 32'h9000_0000;
            3:       e.pc = 32'h7FFF_FFFC;
            4:       e.pc = 32'h8000_0000 + ($urandom & 32'h0FFF_FFFC);
            default: e.pc = $urandom & 32'hFFFF_FFFC;
        endcase
        e.result = $urandom;
        e.bp.predict_address = $urandom;
        return e;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (mon_en && rst_ni) begin
            mon_old = exp_q.size() - new_cnt;
            check("valid", log_valid, mon_old != 0);
            check("stall", stall, (DEPTH - mon_old) < NR);
            check("drop_cnt", drop_cnt, exp_drop());
            if (log_valid && log_ready && mon_old != 0) begin
                mon_e = exp_q.pop_front();
                check("head_rec", log_rec, mon_e[RW-3:0]);
                check("head_priv", log_priv, mon_e[RW-1:RW-2]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        n_cmp = 0; n_bad = 0; mon_en = 1'b0;
        new_cnt = 0; drop_model = 0; drop_pend = 0;
        flush = 1'b0; instr = '0; ack = '0; log_ready = 1'b0;
        fl_m = '0; fl_h = '0; fl_s = '0; fl_u = '0; priv = PRIV_LVL_M;
        ren = 2'b01; rbase = '0; rlim = '0;
        rbase[0] = 32'h8000_0000; rlim[0] = 32'h9000_0000;
        @(posedge clk);
        #1;
        do_reset();

        // Scenario 1: M-mode call inside region 0
        fl_m.is_call = 1'b1;
        set_port(0, CTRL_FLOW, ADD, 5'd1, 5'd0, 32'h8000_0100);
        ack = 2'b01;
        step();
        ack = 2'b00;
        check("t1_valid", log_valid, 1'b1);
        check("t1_pc", log_rec.pc, 32'h8000_0100);
        check("t1_call", log_rec.flags.is_call, 1'b1);
        check("t1_jump", log_rec.flags.is_jump, 1'b1);
        step();
        drain(2);

        // Scenario 2: pc at the exclusive limit, then no windows enabled
        set_port(0, CTRL_FLOW, ADD, 5'd1, 5'd0, 32'h9000_0000);
        ack = 2'b01;
        step();
        ack = 2'b00;
        step();
        check("t2_limit_valid", log_valid, 1'b0);
        ren = 2'b00;
        ack = 2'b01;
        step();
        ack = 2'b00;
        check("t2_noregion_valid", log_valid, 1'b1);
        drain(2);
        ren = 2'b01;

        // Scenario 3: fill with two matches per cycle, overflow, drain
        set_port(0, CTRL_FLOW, ADD, 5'd1, 5'd0, 32'h8000_0200);
        set_port(1, CTRL_FLOW, JALR, 5'd5, 5'd0, 32'h8000_0300);
        ack = 2'b11;
        repeat (4) step();
        check("t3_full_stall", stall, 1'b1);
        step();
        drain(9);

        // Scenario 4: count 7, two matches plus a pop
        ack = 2'b11;
        repeat (3) step();
        ack = 2'b01;
        step();
        check("t4_stall7", stall, 1'b1);
        ack = 2'b11;
        log_ready = 1'b1;
        step();
        ack = 2'b00;
        log_ready = 1'b0;
        check("t4_still7_stall", stall, 1'b1);
        drain(9);

        // Scenario 5: U-mode returns only; valid without commit ack
        priv = PRIV_LVL_U;
        fl_u = '0; fl_u.is_return = 1'b1;
        set_port(0, CTRL_FLOW, JALR, 5'd0, 5'd5, 32'h8000_0400);
        set_port(1, CTRL_FLOW, EQ, 5'd0, 5'd1, 32'h8000_0404);
        ack = 2'b11;
        step();
        ack = 2'b00;
        check("t5_ret_flag", log_rec.flags.is_return, 1'b1);
        drain(3);
        ack = 2'b00;
        step();
        step();
        check("t5_noack_valid", log_valid, 1'b0);

        // Scenario 6: reset with 3 queued, flush with 5 queued
        priv = PRIV_LVL_M;
        set_port(0, CTRL_FLOW, ADD, 5'd1, 5'd0, 32'h8000_0500);
        set_port(1, CTRL_FLOW, ADD, 5'd5, 5'd0, 32'h8000_0504);
        ack = 2'b11;
        step();
        ack = 2'b01;
        step();
        do_reset();
        ack = 2'b11;
        repeat (2) step();
        ack = 2'b01;
        step();
        ack = 2'b00;
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("t6_flush_valid", log_valid, 1'b0);
        check("t6_flush_stall", stall, 1'b0);
        step();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) begin
                fl_m = cfi_flags_t'(6'($urandom));
                fl_h = cfi_flags_t'(6'($urandom));
                fl_s = cfi_flags_t'(6'($urandom));
                fl_u = cfi_flags_t'(6'($urandom));
                ren  = 2'($urandom_range(0, 3));
                rbase[1] = $urandom;
                rlim[1]  = $urandom;
            end
            priv = priv_lvl_t'(2'($urandom_range(0, 3)));
            for (int i = 0; i < NR; i++) instr[i] = rand_instr();
            ack       = 2'($urandom_range(0, 3));
            log_ready = ($urandom_range(0, 1) != 0);
            flush     = ($urandom_range(0, 49) == 0);
            step();
        end
        drain(12);
        check("end_empty", log_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
